// File: rtl/bus_pkg.sv
// Shared types and constants for the per-agent bus sequencer.
// Imported by bus_agent_ctrl and bus_fair_lock.
package bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        ARB,
        OWN,
        REL
    } bus_agent_state_t;

    localparam int LEN_W_DEF      = 4;
    localparam int SETTLE_CYC_MIN = 1;

    // The wired-AND lines need at least one full cycle before grant is valid.
    function automatic bit settle_cyc_ok(input int settle_cyc);
        return settle_cyc >= SETTLE_CYC_MIN;
    endfunction

endpackage

// File: rtl/bus_fair_lock.sv
// Fairness lockout and arbitration-round tracking for one bus agent.
// Drives this agent's PEND contribution and says when it must hold off arbitration.
module bus_fair_lock
    import bus_pkg::*;
#(
    parameter int SETTLE_CYC = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic win,
    input  logic in_wait,
    input  logic in_arb,
    input  logic pend_in,
    input  logic busy_in,
    output logic pend_out,
    output logic arb_block
);

    localparam int OW = $clog2(SETTLE_CYC + 1);
    localparam logic [OW-1:0] OPEN_LOAD = OW'(SETTLE_CYC);
    localparam logic [OW-1:0] OPEN_ONE  = OW'(1);

    logic          lockout;
    logic [OW-1:0] open_cnt;

    // pend_out depends only on registered lockout, so PEND never loops back on itself.
    assign pend_out  = in_arb | (in_wait & ~lockout);

    // A set lockout only blocks while somebody else is pending; PEND low releases it at once.
    assign arb_block = (lockout & pend_in) | (open_cnt != '0);

    // open_cnt marks a round started by others that this agent did not join:
    // PEND seen while not pending itself, on a free bus, blocks entry for a full settle window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lockout  <= 1'b0;
            open_cnt <= '0;
        end else begin
            if (win)
                lockout <= 1'b1;
            else if (!pend_in)
                lockout <= 1'b0;

            if (busy_in)
                open_cnt <= '0;
            else if (pend_in && !pend_out)
                open_cnt <= OPEN_LOAD;
            else if (open_cnt != '0)
                open_cnt <= open_cnt - OPEN_ONE;
        end
    end

endmodule

// File: rtl/bus_agent_ctrl.sv
// Per-agent sequencer: accepts a local request, arbitrates through the agent's
// wired-AND cell, owns the bus for len+1 beats, then releases it for one turnaround cycle.
module bus_agent_ctrl
    import bus_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter int LEN_W      = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [LEN_W-1:0] len,
    output logic             ack,
    output logic             beat,
    output logic             done,
    output logic             arb_get_bus,
    input  logic             arb_granted,
    output logic             busy_out,
    input  logic             busy_in,
    output logic             pend_out,
    input  logic             pend_in
);

    if (!settle_cyc_ok(SETTLE_CYC)) begin : g_settle_chk
        $error("bus_agent_ctrl: SETTLE_CYC must be at least 1");
    end

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [SW-1:0]    SETTLE_ONE  = SW'(1);
    localparam logic [LEN_W-1:0] BEAT_ONE    = LEN_W'(1);

    bus_agent_state_t state, state_nxt;

    logic [SW-1:0]    settle_cnt;
    logic [LEN_W-1:0] beat_cnt;
    logic [LEN_W-1:0] len_q;

    logic in_arb, in_wait, last_settle, last_beat, win, go, arb_block;

    assign in_arb      = (state == ARB);
    // The ack cycle already counts as waiting so simultaneous requesters start together.
    assign in_wait     = (state == WAIT) | ((state == IDLE) & req);
    assign last_settle = (settle_cnt == SETTLE_LAST);
    assign last_beat   = (beat_cnt == len_q);
    assign win         = in_arb & last_settle & arb_granted;
    assign go          = ~arb_block & ~busy_in;

    bus_fair_lock #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_fair_lock (
        .clk       (clk),
        .reset     (reset),
        .win       (win),
        .in_wait   (in_wait),
        .in_arb    (in_arb),
        .pend_in   (pend_in),
        .busy_in   (busy_in),
        .pend_out  (pend_out),
        .arb_block (arb_block)
    );

    always_comb begin
        state_nxt   = state;
        ack         = 1'b0;
        beat        = 1'b0;
        done        = 1'b0;
        arb_get_bus = 1'b0;
        busy_out    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    ack       = 1'b1;
                    state_nxt = go ? ARB : WAIT;
                end
            end
            WAIT: begin
                if (go)
                    state_nxt = ARB;
            end
            ARB: begin
                arb_get_bus = 1'b1;
                // Contention on BUSY is ignored here; the cell has the final word.
                if (last_settle)
                    state_nxt = arb_granted ? OWN : WAIT;
            end
            OWN: begin
                busy_out = 1'b1;
                beat     = 1'b1;
                if (last_beat) begin
                    done      = 1'b1;
                    state_nxt = REL;
                end
            end
            REL: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            settle_cnt <= '0;
            beat_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= (in_arb && !last_settle) ? settle_cnt + SETTLE_ONE : '0;
            beat_cnt   <= ((state == OWN) && !last_beat) ? beat_cnt + BEAT_ONE : '0;
        end
    end

    // Burst length is payload, captured on acceptance only.
    always_ff @(posedge clk) begin
        if (ack)
            len_q <= len;
    end

endmodule
